// File: rtl/bus_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module   : bus_arbiter_if
// Brief    : CPU/DMA requester and memory-bus signals of the bus arbiter.
//            dmaErr exists only when BUS_ARB_IO_PROTECT_EN is defined.
// Revision : 1.0 - initial release
// =============================================================================
interface bus_arbiter_if;
    logic       cpuReq;
    logic       cpuWe;
    logic [7:0] cpuAddr;
    logic [7:0] cpuWdata;
    logic       cpuGnt;
    logic       cpuAck;

    logic       dmaReq;
    logic       dmaWe;
    logic [7:0] dmaAddr;
    logic [7:0] dmaWdata;
    logic       dmaGnt;
    logic       dmaAck;
`ifdef BUS_ARB_IO_PROTECT_EN
    logic       dmaErr;
`endif

    logic [7:0] rdata;

    logic [7:0] busAddr;
    logic [7:0] busWdata;
    logic       busWriteEnable;
    logic       busValid;
    logic [7:0] busRdata;

    // Requester / memory-controller side.
    modport master (
        output cpuReq, cpuWe, cpuAddr, cpuWdata,
        input  cpuGnt, cpuAck,
        output dmaReq, dmaWe, dmaAddr, dmaWdata,
        input  dmaGnt, dmaAck,
        input  rdata,
        input  busAddr, busWdata, busWriteEnable, busValid,
        output busRdata
`ifdef BUS_ARB_IO_PROTECT_EN
        , input dmaErr
`endif
    );

    // Arbiter side.
    modport slave (
        input  cpuReq, cpuWe, cpuAddr, cpuWdata,
        output cpuGnt, cpuAck,
        input  dmaReq, dmaWe, dmaAddr, dmaWdata,
        output dmaGnt, dmaAck,
        output rdata,
        output busAddr, busWdata, busWriteEnable, busValid,
        input  busRdata
`ifdef BUS_ARB_IO_PROTECT_EN
        , output dmaErr
`endif
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : bus_arbiter
// Brief    : CPU/DMA bus arbiter with registered grants, bounded hold and a
//            one-cycle turnaround. Macro BUS_ARB_IO_PROTECT_EN blocks DMA
//            accesses to 0xFC-0xFF and reports them on dmaErr.
// Revision : 1.0 - initial release
// =============================================================================
module bus_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    bus_arbiter_if.slave  ifc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } state_t;

    localparam logic [7:0] c_HOLD_LIMIT = 8'(MAX_HOLD - 1);
    localparam logic [7:0] c_PROT_BASE  = 8'd252;

    state_t     r_state;
    state_t     r_lastOwner;
    logic [7:0] r_holdCount;
    logic       r_cpuGnt;
    logic       r_dmaGnt;

    logic       w_cpuAck;
    logic       w_dmaAck;
    logic       w_dmaAccess;
    logic       w_holdLimit;
    logic       w_busValid;
    logic       w_busWe;
    logic [7:0] w_busAddr;
    logic [7:0] w_busWdata;

    assign w_cpuAck    = r_cpuGnt & ifc.cpuReq;
    assign w_dmaAck    = r_dmaGnt & ifc.dmaReq;
    assign w_holdLimit = (r_holdCount == c_HOLD_LIMIT);

`ifdef BUS_ARB_IO_PROTECT_EN
    logic w_dmaProt;
    // Protected DMA accesses are acked (so the requester moves on) but never reach the bus.
    assign w_dmaProt   = w_dmaAck & (ifc.dmaAddr >= c_PROT_BASE);
    assign w_dmaAccess = w_dmaAck & ~w_dmaProt;
    assign ifc.dmaErr  = w_dmaProt;
`else
    assign w_dmaAccess = w_dmaAck;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lastOwner <= DMA;
            r_holdCount <= 8'd0;
            r_cpuGnt    <= 1'b0;
            r_dmaGnt    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_holdCount <= 8'd0;
                    if (ifc.cpuReq && (!ifc.dmaReq || r_lastOwner == DMA)) begin
                        r_state     <= CPU;
                        r_lastOwner <= CPU;
                        r_cpuGnt    <= 1'b1;
                    end else if (ifc.dmaReq) begin
                        r_state     <= DMA;
                        r_lastOwner <= DMA;
                        r_dmaGnt    <= 1'b1;
                    end
                end
                CPU: begin
                    // Release on request drop, or after the last allowed access when DMA waits.
                    if (!ifc.cpuReq || (ifc.dmaReq && w_holdLimit)) begin
                        r_state     <= IDLE;
                        r_cpuGnt    <= 1'b0;
                        r_holdCount <= 8'd0;
                    end else if (!w_holdLimit) begin
                        r_holdCount <= r_holdCount + 8'd1;
                    end
                end
                DMA: begin
                    if (!ifc.dmaReq || (ifc.cpuReq && w_holdLimit)) begin
                        r_state     <= IDLE;
                        r_dmaGnt    <= 1'b0;
                        r_holdCount <= 8'd0;
                    end else if (!w_holdLimit) begin
                        r_holdCount <= r_holdCount + 8'd1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cpuGnt    <= 1'b0;
                    r_dmaGnt    <= 1'b0;
                    r_holdCount <= 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        w_busValid = 1'b0;
        w_busWe    = 1'b0;
        w_busAddr  = 8'd0;
        w_busWdata = 8'd0;
        if (w_cpuAck) begin
            w_busValid = 1'b1;
            w_busWe    = ifc.cpuWe;
            w_busAddr  = ifc.cpuAddr;
            w_busWdata = ifc.cpuWdata;
        end else if (w_dmaAccess) begin
            w_busValid = 1'b1;
            w_busWe    = ifc.dmaWe;
            w_busAddr  = ifc.dmaAddr;
            w_busWdata = ifc.dmaWdata;
        end
    end

    assign ifc.cpuGnt         = r_cpuGnt;
    assign ifc.dmaGnt         = r_dmaGnt;
    assign ifc.cpuAck         = w_cpuAck;
    assign ifc.dmaAck         = w_dmaAck;
    assign ifc.busValid       = w_busValid;
    assign ifc.busWriteEnable = w_busWe;
    assign ifc.busAddr        = w_busAddr;
    assign ifc.busWdata       = w_busWdata;
    assign ifc.rdata          = (w_cpuAck | w_dmaAck) ? ifc.busRdata : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_bus_arbiter
// Brief    : Self-checking bench for bus_arbiter (vector table + scoreboard).
// Revision : 1.0 - initial release
// =============================================================================
module tb_bus_arbiter;

    localparam int MAX_HOLD = 4;

    typedef struct {
        logic       cReq, cWe;
        logic [7:0] cAddr, cWd;
        logic       dReq, dWe;
        logic [7:0] dAddr, dWd, bRd;
    } in_t;

    typedef struct {
        logic       cGnt, dGnt, cAck, dAck, bValid, bWe;
        logic [7:0] bAddr, bWd, rd;
        logic       err;
    } out_t;

    typedef struct {
        string nm;
        in_t   i;
        out_t  e;
    } vec_t;

    typedef struct {
        string nm;
        out_t  e;
    } sb_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    sb_t  sb[$];
    vec_t tbl[8];

    bus_arbiter_if ifc();

    bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifc   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic in_t mkIn(logic cReq, logic cWe, logic [7:0] cAddr, logic [7:0] cWd,
                                 logic dReq, logic dWe, logic [7:0] dAddr, logic [7:0] dWd,
                                 logic [7:0] bRd);
        in_t r;
        r.cReq = cReq; r.cWe = cWe; r.cAddr = cAddr; r.cWd = cWd;
        r.dReq = dReq; r.dWe = dWe; r.dAddr = dAddr; r.dWd = dWd;
        r.bRd  = bRd;
        return r;
    endfunction

    function automatic out_t mkOut(logic cGnt, logic dGnt, logic cAck, logic dAck,
                                   logic bValid, logic bWe, logic [7:0] bAddr,
                                   logic [7:0] bWd, logic [7:0] rd, logic err);
        out_t r;
        r.cGnt = cGnt; r.dGnt = dGnt; r.cAck = cAck; r.dAck = dAck;
        r.bValid = bValid; r.bWe = bWe; r.bAddr = bAddr; r.bWd = bWd;
        r.rd = rd; r.err = err;
        return r;
    endfunction

    function automatic out_t idleOut();
        return mkOut(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    endfunction

    // Expected outputs for a granted owner completing an access.
    function automatic out_t accOut(bit isCpu, in_t i);
        if (isCpu)
            return mkOut(1, 0, 1, 0, 1, i.cWe, i.cAddr, i.cWd, i.bRd, 0);
        return mkOut(0, 1, 0, 1, 1, i.dWe, i.dAddr, i.dWd, i.bRd, 0);
    endfunction

    function automatic logic [30:0] pk(out_t o);
        return {o.cGnt, o.dGnt, o.cAck, o.dAck, o.bValid, o.bWe, o.bAddr, o.bWd, o.rd, o.err};
    endfunction

    function automatic logic [30:0] actual();
        logic err;
`ifdef BUS_ARB_IO_PROTECT_EN
        err = ifc.dmaErr;
`else
        err = 1'b0;
`endif
        return {ifc.cpuGnt, ifc.dmaGnt, ifc.cpuAck, ifc.dmaAck, ifc.busValid,
                ifc.busWriteEnable, ifc.busAddr, ifc.busWdata, ifc.rdata, err};
    endfunction

    task automatic drive(in_t i);
        ifc.cpuReq   = i.cReq;  ifc.cpuWe    = i.cWe;
        ifc.cpuAddr  = i.cAddr; ifc.cpuWdata = i.cWd;
        ifc.dmaReq   = i.dReq;  ifc.dmaWe    = i.dWe;
        ifc.dmaAddr  = i.dAddr; ifc.dmaWdata = i.dWd;
        ifc.busRdata = i.bRd;
    endtask

    task automatic compare();
        sb_t         s;
        logic [30:0] a;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: nothing expected");
        end else begin
            s = sb.pop_front();
            a = actual();
            if (a !== pk(s.e)) begin
                errors++;
                $display("FAIL %s: got %h required %h (gnt/ack/valid/we/addr/wdata/rdata/err)",
                         s.nm, a, pk(s.e));
            end
        end
    endtask

    task automatic checkNow(string nm, out_t e);
        sb_t s;
        s.nm = nm;
        s.e  = e;
        sb.push_back(s);
        compare();
    endtask

    task automatic step(string nm, in_t i, out_t e);
        @(negedge clk);
        drive(i);
        #2;
        checkNow(nm, e);
    endtask

    task automatic doReset();
        @(negedge clk);
        drive(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        tbl[0] = '{"t_idle_req",   mkIn(1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 8'h33), idleOut()};
        tbl[1] = '{"t_cpu_write",  mkIn(1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 8'h33),
                   mkOut(1,0,1,0,1,1,8'h10,8'hA5,8'h33,0)};
        tbl[2] = '{"t_cpu_read",   mkIn(1,0,8'h11,8'hA5, 0,0,8'h00,8'h00, 8'h44),
                   mkOut(1,0,1,0,1,0,8'h11,8'hA5,8'h44,0)};
        tbl[3] = '{"t_cpu_drop",   mkIn(0,1,8'h12,8'h77, 0,0,8'h00,8'h00, 8'h55),
                   mkOut(1,0,0,0,0,0,8'h00,8'h00,8'h00,0)};
        tbl[4] = '{"t_back_idle",  mkIn(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 8'h55), idleOut()};
        tbl[5] = '{"t_dma_idle",   mkIn(0,0,8'h00,8'h00, 1,1,8'h30,8'h5C, 8'h66), idleOut()};
        tbl[6] = '{"t_dma_write",  mkIn(0,0,8'h00,8'h00, 1,1,8'h30,8'h5C, 8'h66),
                   mkOut(0,1,0,1,1,1,8'h30,8'h5C,8'h66,0)};
        tbl[7] = '{"t_dma_cpu_wait", mkIn(1,1,8'h40,8'h11, 1,0,8'h31,8'h00, 8'h77),
                   mkOut(0,1,0,1,1,0,8'h31,8'h00,8'h77,0)};

        // Reset held with both requests high: nothing may be granted.
        rst_n = 1'b0;
        drive(mkIn(1,1,8'h10,8'hA5, 1,1,8'h20,8'h5A, 8'hEE));
        step("rst_hold0", mkIn(1,1,8'h10,8'hA5, 1,1,8'h20,8'h5A, 8'hEE), idleOut());
        step("rst_hold1", mkIn(1,1,8'h10,8'hA5, 1,1,8'h20,8'h5A, 8'hEE), idleOut());
        @(negedge clk);
        drive(mkIn(0,0,0,0,0,0,0,0,0));
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++)
            step(tbl[v].nm, tbl[v].i, tbl[v].e);

        // Both requesters saturating the bus: 4 CPU, idle, 4 DMA, idle, ...
        doReset();
        for (int k = 0; k < 25; k++) begin
            in_t i;
            int  ph;
            i  = mkIn(1, k[0], 8'(8'h20 + k), 8'(k * 3), 1, ~k[0], 8'(8'h80 + k), ~8'(k), 8'(8'h40 + k));
            ph = k % 10;
            if (ph >= 1 && ph <= 4)
                step($sformatf("rot_cpu_k%0d", k), i, accOut(1, i));
            else if (ph >= 6)
                step($sformatf("rot_dma_k%0d", k), i, accOut(0, i));
            else
                step($sformatf("rot_idle_k%0d", k), i, idleOut());
        end

        // DMA alone: back-to-back reads, hold saturates, then CPU gets the bus after one more.
        doReset();
        step("dma_only_idle", mkIn(0,0,0,0, 1,0,8'h00,8'h00, 8'h01), idleOut());
        for (int k = 0; k < 10; k++) begin
            in_t i;
            i = mkIn(0,0,0,0, 1,0,8'(k),8'h00, 8'(k + 1));
            step($sformatf("dma_read_%0d", k), i, accOut(0, i));
        end
        begin
            in_t i;
            i = mkIn(1,1,8'hC0,8'h3C, 1,0,8'h0A,8'h00, 8'h0B);
            step("dma_sat_release", i, accOut(0, i));
            step("dma_turnaround", i, idleOut());
            step("cpu_after_dma", i, accOut(1, i));
        end

        // Asynchronous reset in the middle of a DMA write.
        doReset();
        begin
            in_t i;
            i = mkIn(0,0,8'h50,8'h00, 1,1,8'h44,8'h99, 8'h00);
            step("r27_idle", i, idleOut());
            step("r27_dma_write", i, accOut(0, i));
            i = mkIn(1,0,8'h50,8'h00, 1,1,8'h44,8'h99, 8'h12);
            drive(i);
            rst_n = 1'b0;
            #1;
            checkNow("r27_async_rst", idleOut());
            @(negedge clk);
            #2;
            checkNow("r27_rst_held", idleOut());
            rst_n = 1'b1;
            #1;
            checkNow("r27_rst_release", idleOut());
            step("r27_cpu_wins", i, accOut(1, i));
            step("r27_cpu_second", i, accOut(1, i));
            // Last owner is now CPU; reset must return it to DMA so CPU wins again.
            #1;
            rst_n = 1'b0;
            #1;
            checkNow("r27_rst_during_cpu", idleOut());
            @(negedge clk);
            rst_n = 1'b1;
            step("r27_cpu_wins_again", i, accOut(1, i));
        end

        // Protected I/O window at the top of the DMA address space.
        doReset();
        begin
            in_t i;
            i = mkIn(0,0,0,0, 1,1,8'hFC,8'hFF, 8'h5A);
            step("io_idle", i, idleOut());
`ifdef BUS_ARB_IO_PROTECT_EN
            step("io_fc_blocked", i, mkOut(0,1,0,1,0,0,8'h00,8'h00,8'h5A,1));
`else
            step("io_fc_open", i, accOut(0, i));
`endif
            i = mkIn(0,0,0,0, 1,1,8'hFB,8'hFF, 8'h5B);
            step("io_fb_open", i, accOut(0, i));
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4: maximum consecutive granted accesses by one owner while the other requester waits.
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports cpuReq, cpuWe  input  1 each  CPU access request and write qualifier.
REQ-005 The block SHALL have ports cpuAddr, cpuWdata  input  8 each  CPU address and write data.
REQ-006 The block SHALL have ports cpuGnt, cpuAck  output  1 each  CPU owns bus; CPU access completes this cycle.
REQ-007 The block SHALL have ports dmaReq, dmaWe, dmaAddr[7:0], dmaWdata[7:0] (input) and dmaGnt, dmaAck (output), with the same meanings for the DMA/loader requester.
REQ-008 The block SHALL have port rdata  output  8  busRdata passed through to whichever requester is acked.
REQ-009 The block SHALL have ports busAddr, busWdata  output  8 each and busWriteEnable, busValid  output  1 each, driving the memory controller address decode; busRdata  input  8.

Function
REQ-010 The FSM SHALL have states IDLE, CPU, DMA; exactly one of cpuGnt/dmaGnt is high in CPU/DMA, both low in IDLE.
REQ-011 From IDLE, the FSM SHALL enter CPU if only cpuReq, DMA if only dmaReq; if both, the requester that was not the last owner wins (last owner resets to DMA, so CPU wins first).
REQ-012 Grants SHALL be registered: a request seen in IDLE at edge N yields the grant from edge N, first access in the following cycle.
REQ-013 In CPU (DMA) with cpuReq (dmaReq) high, busValid SHALL be 1, bus outputs SHALL mirror the owner's addr/wdata, busWriteEnable = owner We, ownerAck = 1 that cycle.
REQ-014 When not granted, or owner request low, busValid, busWriteEnable, both acks SHALL be 0 and busAddr/busWdata 0.
REQ-015 The owner dropping its request SHALL return the FSM to IDLE at the next edge; no access occurs in that cycle.
REQ-016 An 8-bit holdCount SHALL count acked accesses of the current owner and clear on every grant change and in IDLE.
REQ-017 When holdCount reaches MAX_HOLD-1 on an acked access while the other requester is high, the FSM SHALL go to IDLE at that edge (one dead turnaround cycle) and then grant the other requester.
REQ-018 With the other requester low, the owner SHALL keep the bus indefinitely; holdCount saturates at MAX_HOLD-1.
REQ-019 Requests rising simultaneously with a forced release SHALL follow REQ-011 fairness.
REQ-020 rdata SHALL equal busRdata combinationally when either ack is high, else 0.

Reset
REQ-021 rst_n low SHALL force, asynchronously, state IDLE, lastOwner DMA, holdCount 0, all grants/acks/bus outputs 0; an access in flight is abandoned with no ack.
REQ-022 After rst_n rises, the first grant SHALL occur no earlier than the first clk edge with a request high.

Configuration
REQ-023 With BUS_ARB_IO_PROTECT_EN defined, DMA accesses to addresses 252-255 SHALL be acked with busValid=0 and busWriteEnable=0, and output dmaErr (1 bit) SHALL pulse high that cycle; without it, dmaErr SHALL be absent and DMA reaches all 256 addresses.

Verification
REQ-024 Reset, then cpuReq=1, cpuAddr=0x10, cpuWe=1, cpuWdata=0xA5 -> cpuGnt from next edge, busAddr=0x10, busWriteEnable=1, busWdata=0xA5, cpuAck=1.
REQ-025 cpuReq and dmaReq held high from IDLE, MAX_HOLD=4 -> 4 CPU acks, 1 idle cycle, 4 DMA acks, 1 idle cycle, repeat.
REQ-026 dmaReq only, 10 reads at 0x00-0x09, busRdata=addr+1 -> 10 dmaAcks, rdata 0x01-0x0A, holdCount saturated at 3, no idle cycles.
REQ-027 rst_n pulled low mid-DMA write -> same-cycle busValid=0, dmaGnt=0, state IDLE; after release CPU wins a simultaneous request.
REQ-028 BUS_ARB_IO_PROTECT_EN defined, DMA write 0xFF to 0xFC -> dmaAck=1, dmaErr=1, busValid=0, busWriteEnable=0; undefined -> busValid=1, busAddr=0xFC.
